// File: rtl/seed_round_sequencer_if.sv
// Control/status bundle between the SEED round sequencer and its datapath/host.
interface seed_round_sequencer_if;
    logic       start;
    logic       decrypt;
    logic       in_valid;
    logic       out_ready;
    logic       ready;
    logic       load_en;
    logic [3:0] byte_idx;
    logic [4:0] main_counter;
    logic [3:0] round_idx;
    logic [3:0] key_idx;
    logic       g_enable;
    logic       carry_enable;
    logic       last_round;
    logic       out_valid;
    logic       done;

    modport master (
        output start, decrypt, in_valid, out_ready,
        input  ready, load_en, byte_idx, main_counter, round_idx, key_idx,
               g_enable, carry_enable, last_round, out_valid, done
    );

    modport slave (
        input  start, decrypt, in_valid, out_ready,
        output ready, load_en, byte_idx, main_counter, round_idx, key_idx,
               g_enable, carry_enable, last_round, out_valid, done
    );
endinterface

// File: rtl/seed_round_sequencer.sv
// SEED block sequencer: loads 16 bytes, runs NUM_ROUNDS fixed-length rounds,
// then unloads 16 bytes, driving the per-cycle controls of the F datapath.
module seed_round_sequencer #(
    parameter int unsigned NUM_ROUNDS   = 16,
    parameter int unsigned ROUND_CYCLES = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    seed_round_sequencer_if.slave bus
);
    localparam int unsigned BYTE_W = 4;
    localparam int unsigned CTR_W  = 5;
    localparam int unsigned RND_W  = 4;

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(15);
    localparam logic [CTR_W-1:0]  LAST_CTR  = CTR_W'(ROUND_CYCLES - 1);
    localparam logic [RND_W-1:0]  LAST_RND  = RND_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ROUND  = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BYTE_W-1:0]   r_byte;
    logic [BYTE_W-1:0]   w_byte_nxt;
    logic [CTR_W-1:0]    r_ctr;
    logic [CTR_W-1:0]    w_ctr_nxt;
    logic [RND_W-1:0]    r_round;
    logic [RND_W-1:0]    w_round_nxt;
    logic                r_decrypt;
    logic                w_decrypt_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_in_round;

    // State and counter registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_byte    <= '0;
            r_ctr     <= '0;
            r_round   <= '0;
            r_decrypt <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_byte    <= w_byte_nxt;
            r_ctr     <= w_ctr_nxt;
            r_round   <= w_round_nxt;
            r_decrypt <= w_decrypt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Counters are cleared on every phase exit so they read 0 outside their phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_byte_nxt    = r_byte;
        w_ctr_nxt     = r_ctr;
        w_round_nxt   = r_round;
        w_decrypt_nxt = r_decrypt;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = S_LOAD;
                    w_decrypt_nxt = bus.decrypt;
                    w_byte_nxt    = '0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (r_byte == LAST_BYTE) begin
                        w_state_nxt = S_ROUND;
                        w_byte_nxt  = '0;
                    end else begin
                        w_byte_nxt = r_byte + BYTE_W'(1);
                    end
                end
            end
            S_ROUND: begin
                if (r_ctr == LAST_CTR) begin
                    w_ctr_nxt = '0;
                    if (r_round == LAST_RND) begin
                        w_state_nxt = S_UNLOAD;
                        w_round_nxt = '0;
                    end else begin
                        w_round_nxt = r_round + RND_W'(1);
                    end
                end else begin
                    w_ctr_nxt = r_ctr + CTR_W'(1);
                end
            end
            S_UNLOAD: begin
                if (bus.out_ready) begin
                    if (r_byte == LAST_BYTE) begin
                        w_state_nxt = S_IDLE;
                        w_byte_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_byte_nxt = r_byte + BYTE_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_in_round = (r_state == S_ROUND);

    // Output decode uses registered state only; load_en is the one input-qualified strobe.
    assign bus.ready        = (r_state == S_IDLE);
    assign bus.load_en      = bus.in_valid && (r_state == S_LOAD);
    assign bus.out_valid    = (r_state == S_UNLOAD);
    assign bus.byte_idx     = r_byte;
    assign bus.main_counter = r_ctr;
    assign bus.round_idx    = r_round;
    assign bus.key_idx      = !w_in_round ? '0 :
                              (r_decrypt ? (LAST_RND - r_round) : r_round);
    assign bus.last_round   = w_in_round && (r_round == LAST_RND);
    assign bus.g_enable     = w_in_round &&
                              ((r_ctr <= CTR_W'(2)) ||
                               ((r_ctr >= CTR_W'(4)) && (r_ctr <= CTR_W'(16))));
    assign bus.carry_enable = w_in_round &&
                              ((r_ctr <= CTR_W'(2)) ||
                               ((r_ctr >= CTR_W'(9))  && (r_ctr <= CTR_W'(11))) ||
                               ((r_ctr >= CTR_W'(13)) && (r_ctr <= CTR_W'(15))));
    assign bus.done         = r_done;
endmodule
